// File: rtl/cpu_step_ctrl_pkg.sv
// cpu_step_ctrl_pkg: state codes and default halt opcode shared by the step sequencer.
// The breakpoint state is only reachable when CPU_STEP_BRK_EN is defined.
package cpu_step_ctrl_pkg;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_BRK  = 3'd2;
    localparam logic [2:0] ST_HALT = 3'd3;
    localparam logic [5:0] HALT_OP_DEF = 6'b111111;
endpackage

// File: rtl/cpu_step_ctrl_step_rate_div.sv
// step_rate_div: DIV-cycle rate counter with synchronous clear; tick marks the terminal count.
module step_rate_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt;
    assign tick = en && (cnt == W'(DIV - 1));
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: issues one-cycle cpu_step pulses from key presses or a divided run rate, halts on HALT_OP.
// Optional PC breakpoint in run mode is enabled by defining CPU_STEP_BRK_EN.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int         RUN_DIV = 25000000,
    parameter logic [5:0] HALT_OP = HALT_OP_DEF,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             key_in,
    input  logic             run_sw,
    input  logic [31:0]      pc,
    input  logic [5:0]       op,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_step,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);
    logic key_d, press, tick, cand, halt_hit, bp_hit, step_n;
    logic [2:0] state_n;

    step_rate_div #(.DIV(RUN_DIV)) u_div (
        .clk  (clk),
        .nRST (nRST),
        .clr  (state != ST_RUN),
        .en   (state == ST_RUN),
        .tick (tick)
    );

    assign press = key_in && !key_d;
`ifdef CPU_STEP_BRK_EN
    assign bp_hit = bp_valid && (pc == bp_addr);
`else
    logic unused_brk;
    assign unused_brk = ^{bp_addr, bp_valid, pc};
    assign bp_hit = 1'b0;
`endif
    // A step candidate is checked against HALT_OP before anything else may act on it.
    assign cand = ((state == ST_IDLE || state == ST_BRK) && press) || tick;
    assign halt_hit = cand && (op == HALT_OP);

    always_comb begin
        state_n = state;
        step_n = 1'b0;
        if (halt_hit)
            state_n = ST_HALT;
        else if (tick && bp_hit)
            state_n = ST_BRK;
        else if (state == ST_IDLE && run_sw)
            state_n = ST_RUN;
        else if (state == ST_RUN && !run_sw)
            state_n = ST_IDLE;
        else if (state == ST_BRK && press) begin
            step_n = 1'b1;
            state_n = run_sw ? ST_RUN : ST_IDLE;
        end
        else if (state == ST_BRK && !run_sw)
            state_n = ST_IDLE;
        else
            step_n = cand;
    end

    // key_d resets high so a key held through reset must be released before it counts.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            key_d <= 1'b1;
            state <= ST_IDLE;
            cpu_step <= 1'b0;
            halted <= 1'b0;
            step_count <= '0;
        end else begin
            key_d <= key_in;
            state <= state_n;
            cpu_step <= step_n;
            halted <= (state_n == ST_HALT);
            if (step_n)
                step_count <= step_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed and randomized checks of cpu_step_ctrl against a cycle-count reference model.
// Breakpoint expectations follow CPU_STEP_BRK_EN when it is defined for the build.
module tb_cpu_step_ctrl;
    localparam int RUN_DIV = 4;

    logic        clk = 0;
    logic        nRST = 0;
    logic        key_in = 1;
    logic        run_sw = 0;
    logic [31:0] pc = 0;
    logic [5:0]  op = 0;
    logic [31:0] bp_addr = 0;
    logic        bp_valid = 0;
    logic        cpu_step;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] step_count;

    int pass_cnt = 0;
    int total = 0;

    // reference model: mode code, edges since RUN entry, last key level, expected outputs
    logic [2:0]  m_state;
    int          m_run;
    logic        m_key;
    logic        m_step;
    logic        m_halted;
    logic [15:0] m_count;

    cpu_step_ctrl #(.RUN_DIV(RUN_DIV), .HALT_OP(6'h3F), .CNT_W(16)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .key_in     (key_in),
        .run_sw     (run_sw),
        .pc         (pc),
        .op         (op),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .cpu_step   (cpu_step),
        .state      (state),
        .halted     (halted),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    function automatic bit bp_match();
`ifdef CPU_STEP_BRK_EN
        return bp_valid && pc == bp_addr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_key = 1; m_step = 0; m_halted = 0; m_count = 0;
    endtask

    // Advance the model by one clock edge from the current inputs, then clock the DUT.
    task automatic cyc();
        bit press, due, wants;
        logic [2:0] nxt;
        int run_nxt;
        press = key_in && !m_key;
        due = (m_state == 1) && ((m_run + 1) % RUN_DIV == 0);
        wants = due || ((m_state == 0 || m_state == 2) && press);
        nxt = m_state;
        run_nxt = m_run + 1;
        m_step = 0;
        if (wants && op == 6'h3F) nxt = 3;
        else if (due && bp_match()) nxt = 2;
        else if (m_state == 0 && run_sw) nxt = 1;
        else if (m_state == 1 && !run_sw) nxt = 0;
        else if (m_state == 2 && press) begin m_step = 1; nxt = run_sw ? 3'd1 : 3'd0; end
        else if (m_state == 2 && !run_sw) nxt = 0;
        else m_step = wants;
        if (nxt == 1 && m_state != 1) run_nxt = 0;
        m_run = run_nxt;
        if (m_step) m_count = m_count + 16'd1;
        m_key = key_in;
        m_state = nxt;
        m_halted = (nxt == 3);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nRST = 0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        nRST = 1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        key_in = 1;
        nRST = 0;
        #1;
        model_reset();
        total++;
        if (state !== 3'd0 || cpu_step !== 1'b0 || halted !== 1'b0 || step_count !== 16'd0)
            $display("FAIL reset_vals: state=%0d step=%b halted=%b count=%0d want 0/0/0/0", state, cpu_step, halted, step_count);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        nRST = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (cpu_step !== 1'b0) $display("FAIL held_key_no_step: cycle %0d step=%b want 0", i, cpu_step);
            else pass_cnt++;
        end
        key_in = 0; cyc();
        key_in = 1; cyc();
        total++;
        if (cpu_step !== 1'b1 || step_count !== 16'd1)
            $display("FAIL key_step: step=%b count=%0d want 1/1", cpu_step, step_count);
        else pass_cnt++;
        cyc();
        total++;
        if (cpu_step !== 1'b0 || step_count !== 16'd1)
            $display("FAIL key_single: step=%b count=%0d want 0/1", cpu_step, step_count);
        else pass_cnt++;
    endtask

    task automatic test_run();
        logic [15:0] c0;
        key_in = 0; op = 0; cyc();
        c0 = step_count;
        run_sw = 1; cyc();
        total++;
        if (state !== 3'd1 || cpu_step !== 1'b0) $display("FAIL run_entry: state=%0d step=%b want 1/0", state, cpu_step);
        else pass_cnt++;
        for (int i = 1; i <= 20; i++) begin
            key_in = i[0];
            cyc();
            total++;
            if (cpu_step !== (i % RUN_DIV == 0) || cpu_step !== m_step)
                $display("FAIL run_pulse: cycle %0d step=%b want %b", i, cpu_step, i % RUN_DIV == 0);
            else pass_cnt++;
        end
        total++;
        if (step_count !== c0 + 16'd5 || step_count !== m_count)
            $display("FAIL run_count: count=%0d want %0d", step_count, c0 + 16'd5);
        else pass_cnt++;
    endtask

    task automatic test_run_drop();
        key_in = 0;
        cyc(); cyc();
        run_sw = 0; cyc();
        total++;
        if (cpu_step !== 1'b0 || state !== 3'd0) $display("FAIL run_drop: step=%b state=%0d want 0/0", cpu_step, state);
        else pass_cnt++;
        run_sw = 1; cyc();
        for (int j = 1; j <= 4; j++) begin
            cyc();
            total++;
            if (cpu_step !== (j == 4) || state !== 3'd1)
                $display("FAIL run_reentry: cycle %0d step=%b state=%0d want %b/1", j, cpu_step, state, j == 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_halt_run();
        logic [15:0] c0;
        run_sw = 0; cyc();
        run_sw = 1; op = 6'h3F; cyc();
        c0 = step_count;
        repeat (3) cyc();
        cyc();
        total++;
        if (cpu_step !== 1'b0 || state !== 3'd3 || halted !== 1'b1 || step_count !== c0)
            $display("FAIL halt_run: step=%b state=%0d halted=%b count=%0d want 0/3/1/%0d", cpu_step, state, halted, step_count, c0);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            key_in = i[0]; run_sw = i[2]; op = 6'(i);
            cyc();
            total++;
            if (cpu_step !== 1'b0 || state !== 3'd3 || halted !== 1'b1)
                $display("FAIL halt_sticky: cycle %0d step=%b state=%0d halted=%b want 0/3/1", i, cpu_step, state, halted);
            else pass_cnt++;
        end
        do_reset();
        total++;
        if (halted !== 1'b0 || state !== 3'd0 || step_count !== 16'd0)
            $display("FAIL halt_reset: halted=%b state=%0d count=%0d want 0/0/0", halted, state, step_count);
        else pass_cnt++;
        run_sw = 0; op = 0;
    endtask

    task automatic test_idle_halt();
        logic [15:0] c0;
        key_in = 0; op = 0; run_sw = 0;
        cyc();
        key_in = 1; cyc();
        key_in = 0; cyc();
        c0 = step_count;
        op = 6'h3F; key_in = 1; cyc();
        total++;
        if (cpu_step !== 1'b0 || state !== 3'd3 || halted !== 1'b1 || step_count !== c0)
            $display("FAIL idle_halt: step=%b state=%0d halted=%b count=%0d want 0/3/1/%0d", cpu_step, state, halted, step_count, c0);
        else pass_cnt++;
        do_reset();
        op = 0;
    endtask

    task automatic test_breakpoint();
        key_in = 0; op = 0; bp_valid = 1; bp_addr = 32'h10; pc = 32'h10;
        cyc();
        run_sw = 1; cyc();
        repeat (3) cyc();
        cyc();
`ifdef CPU_STEP_BRK_EN
        total++;
        if (cpu_step !== 1'b0 || state !== 3'd2) $display("FAIL brk_hit: step=%b state=%0d want 0/2", cpu_step, state);
        else pass_cnt++;
        pc = 32'h14; key_in = 1; cyc();
        total++;
        if (cpu_step !== 1'b1 || state !== 3'd1) $display("FAIL brk_resume: step=%b state=%0d want 1/1", cpu_step, state);
        else pass_cnt++;
`else
        total++;
        if (cpu_step !== 1'b1 || state !== 3'd1) $display("FAIL brk_disabled: step=%b state=%0d want 1/1", cpu_step, state);
        else pass_cnt++;
`endif
        bp_valid = 0; run_sw = 0; key_in = 0;
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] pcs [3];
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h20;
        bp_addr = 32'h10;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) key_in = ~key_in;
            if ($urandom_range(0, 11) == 0) run_sw = ~run_sw;
            op = ($urandom_range(0, 59) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
            pc = pcs[$urandom_range(0, 2)];
            bp_valid = 1'($urandom_range(0, 1));
            if (m_state == 3 && $urandom_range(0, 7) == 0) do_reset();
            cyc();
            total++;
            if (cpu_step !== m_step || state !== m_state || halted !== m_halted || step_count !== m_count)
                $display("FAIL random: cycle %0d got step=%b state=%0d halted=%b count=%0d want %b/%0d/%b/%0d",
                         i, cpu_step, state, halted, step_count, m_step, m_state, m_halted, m_count);
            else pass_cnt++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run();
        test_run_drop();
        test_halt_run();
        test_idle_halt();
        test_breakpoint();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
